general_reg_mp: RTL and testbench
=================================

# general_reg_mp

Parametrised multi-port general-purpose register file for the CPU core. Replaces the fixed 32x32, two-read, one-write register file with configurable width, depth and read-port count, plus a second write port for dual retirement. Adds same-cycle write-to-read bypass and a hardware clear sweep on reset or on request. Sits between decode (read ports) and writeback (write ports).

## Interface

- XLEN, 32: register width in bits.
- AW, 5: address width; DEPTH = 2**AW entries.
- NRD, 2: number of read ports.
- ZERO_REG, 1: 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register.

- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- i_clear  input  1  request a full clear sweep; sampled only when o_busy=0.
- o_busy  output  1  high while the clear sweep runs; reads and writes are ignored.
- i_write_flag0 / i_write_flag1  input  1 each  write enables, ports 0 and 1.
- i_write_addr0 / i_write_addr1  input  AW each  write addresses.
- i_write_data0 / i_write_data1  input  XLEN each  write data.
- i_read_flag  input  NRD  per-port read enables.
- i_read_addr  input  NRD*AW  read addresses; port k is bits [k*AW +: AW].
- o_read_data  output  NRD*XLEN  registered read data; port k is bits [k*XLEN +: XLEN].
- o_read_valid  output  NRD  registered copy of the accepted read enables.

## Operation

- FSM states: CLEAR, IDLE. Sweep counter clr_idx is AW bits wide.
- rst=0 at an edge: state<=CLEAR, clr_idx<=0, o_read_data<=0, o_read_valid<=0. o_busy reads 1 on the following cycle. No array write occurs while rst=0.
- CLEAR with rst=1: each edge writes 0 to entry clr_idx, then increments clr_idx. On the edge that clears entry DEPTH-1, state goes to IDLE and clr_idx wraps to 0.
- o_busy = (state==CLEAR), driven from a register.
- While busy: write flags, read flags and i_clear are ignored. o_read_data=0 and o_read_valid=0.
- IDLE with i_clear=1: the next state is CLEAR with clr_idx=0. Writes in that cycle are discarded. Reads in that cycle are still served.
- Writes, in IDLE only:
  - A port with its flag high writes its data at the edge.
  - Address 0 is dropped when ZERO_REG=1.
  - If both ports target the same address, port 1 wins.
- Reads, in IDLE only: for each port k, at the edge:
  - Flag low: data<=0, valid<=0.
  - Flag high, addr==0 and ZERO_REG=1: data<=0, valid<=1.
  - Otherwise valid<=1 and data is selected in priority order: port-1 write data on an address match with an effective write, else port-0 write data on a match, else the array entry.
- Bypass is taken only from writes that actually commit in the same cycle; dropped writes (address 0, i_clear, busy) never bypass.

## Timing

- Read latency is 1 cycle: inputs at edge N appear on o_read_data / o_read_valid after edge N. Outputs hold until the next edge.
- Write-to-read is 0 cycles: a read at the same edge as a write returns the new data.
- Sweep length:
  - After reset release: DEPTH edges. o_busy is high for DEPTH cycles after the first rst=1 edge, and the first accepted access is in cycle DEPTH+1.
  - After i_clear: o_busy is high for DEPTH cycles starting the cycle after the request.
- Reset mid-sweep restarts the sweep from clr_idx=0.
- Reset value of every output: o_read_data=0, o_read_valid=0, o_busy=1.
- Write and read flags are qualified levels; there is no handshake and no back-pressure beyond o_busy.

## Test plan

- Reset sweep: hold rst=0 for 3 cycles, release. With DEPTH=32, o_busy is 1 for exactly 32 cycles after release and then 0. Reading every address returns 0x00000000 with valid=1.
- Write/read and bypass:
  - Write 0xDEADBEEF to x5 via port 0, then read x5 next cycle -> 0xDEADBEEF.
  - Write 0x12345678 to x7 while port 1 reads x7 at the same edge -> 0x12345678 one cycle later.
- Collision: both ports write x9 in one cycle (port0=0x1111, port1=0x2222) with a same-cycle read of x9 -> 0x2222. A later read of x9 -> 0x2222.
- x0: with ZERO_REG=1, write 0xFFFFFFFF to x0 with a same-cycle read of x0 -> 0, valid=1. With ZERO_REG=0 the same sequence returns 0xFFFFFFFF on a read the next cycle.
- Disabled read: after loading x3=0xA5A5A5A5, assert read flag=0 on x3 -> data 0, valid 0.
- Clear mid-operation:
  - Load x1..x4, pulse i_clear, and attempt a write of 0x77 to x2 during busy. After o_busy falls, x1..x4 all read 0.
  - Assert rst=0 at sweep cycle 10: the sweep restarts and o_busy stays high for 32 cycles after release.

Source files
------------

// File: rtl/general_reg_mp.sv
// Multi-port general-purpose register file: two write ports, NRD registered read
// ports with same-cycle write bypass, and a hardware clear sweep on reset/request.
module general_reg_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  output logic                o_busy,
  input  logic                i_write_flag0,
  input  logic                i_write_flag1,
  input  logic [AW-1:0]       i_write_addr0,
  input  logic [AW-1:0]       i_write_addr1,
  input  logic [XLEN-1:0]     i_write_data0,
  input  logic [XLEN-1:0]     i_write_data1,
  input  logic [NRD-1:0]      i_read_flag,
  input  logic [NRD*AW-1:0]   i_read_addr,
  output logic [NRD*XLEN-1:0] o_read_data,
  output logic [NRD-1:0]      o_read_valid
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic [XLEN-1:0]     mem_q [DEPTH];
  logic [XLEN-1:0]     mem_d [DEPTH];
  logic [NRD*XLEN-1:0] read_data_q, read_data_d;
  logic [NRD-1:0]      read_valid_q, read_valid_d;
  logic [AW-1:0]       rd_addr [NRD];
  logic                idle;
  logic                wr_en0, wr_en1;

  assign idle = (state_q == IDLE);

  // Effective writes: only these commit and only these may bypass to reads.
  always_comb begin
    wr_en0 = idle && !i_clear && i_write_flag0
             && !((ZERO_REG != 0) && (i_write_addr0 == '0));
    wr_en1 = idle && !i_clear && i_write_flag1
             && !((ZERO_REG != 0) && (i_write_addr1 == '0));
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (i_clear) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (state_q == CLEAR) begin
      mem_d[clr_idx_q] = '0;
    end
    if (wr_en0) begin
      mem_d[i_write_addr0] = i_write_data0;
    end
    if (wr_en1) begin
      mem_d[i_write_addr1] = i_write_data1;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_addr[k] = i_read_addr[k*AW +: AW];
    end
  end

  always_comb begin
    read_data_d  = '0;
    read_valid_d = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (idle && i_read_flag[k]) begin
        read_valid_d[k] = 1'b1;
        if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
          read_data_d[k*XLEN +: XLEN] = '0;
        end else if (wr_en1 && (i_write_addr1 == rd_addr[k])) begin
          read_data_d[k*XLEN +: XLEN] = i_write_data1;
        end else if (wr_en0 && (i_write_addr0 == rd_addr[k])) begin
          read_data_d[k*XLEN +: XLEN] = i_write_data0;
        end else begin
          read_data_d[k*XLEN +: XLEN] = mem_q[rd_addr[k]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // The array itself is never touched while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign o_busy       = (state_q == CLEAR);
  assign o_read_data  = read_data_q;
  assign o_read_valid = read_valid_q;

endmodule

// File: tb/tb_general_reg_mp.sv
// Self-checking bench for general_reg_mp: two instances (ZERO_REG=1 and 0) share
// stimulus and are compared every cycle against a behavioural register-file model.
module tb_general_reg_mp;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        wf0 = 1'b0, wf1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [1:0]  rf = '0;
  logic [9:0]  ra = '0;

  logic [63:0] rd_z1, rd_z0;
  logic [1:0]  rv_z1, rv_z0;
  logic        busy_z1, busy_z0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  general_reg_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .i_clear(clr), .o_busy(busy_z1),
    .i_write_flag0(wf0), .i_write_flag1(wf1),
    .i_write_addr0(wa0), .i_write_addr1(wa1),
    .i_write_data0(wd0), .i_write_data1(wd1),
    .i_read_flag(rf), .i_read_addr(ra),
    .o_read_data(rd_z1), .o_read_valid(rv_z1)
  );

  general_reg_mp #(.XLEN(32), .AW(5), .NRD(2), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .i_clear(clr), .o_busy(busy_z0),
    .i_write_flag0(wf0), .i_write_flag1(wf1),
    .i_write_addr0(wa0), .i_write_addr1(wa1),
    .i_write_data0(wd0), .i_write_data1(wd1),
    .i_read_flag(rf), .i_read_addr(ra),
    .o_read_data(rd_z0), .o_read_valid(rv_z0)
  );

  // Model: index 1 = ZERO_REG=1 instance, index 0 = ZERO_REG=0 instance.
  logic [31:0] mm [2][DEPTH];
  logic [31:0] nm [DEPTH];
  logic [63:0] e_rd [2];
  logic [1:0]  e_rv [2];
  int          busy_left = 0;
  bit          model_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] port(input logic [63:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  // A sweep zeroes every entry; since nothing is observable while busy, the model
  // zeroes at sweep start and just counts down the busy period.
  always @(posedge clk) begin
    if (!rst) begin
      model_on  = 1'b1;
      busy_left = DEPTH;
      for (int d = 0; d < 2; d++) begin
        e_rd[d] = '0;
        e_rv[d] = '0;
        for (int i = 0; i < DEPTH; i++) mm[d][i] = '0;
      end
    end else if (model_on) begin
      if (busy_left > 0) begin
        busy_left--;
        for (int d = 0; d < 2; d++) begin
          e_rd[d] = '0;
          e_rv[d] = '0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          for (int i = 0; i < DEPTH; i++) nm[i] = mm[d][i];
          if (!clr) begin
            if (wf0 && !(d == 1 && wa0 == 5'd0)) nm[wa0] = wd0;
            if (wf1 && !(d == 1 && wa1 == 5'd0)) nm[wa1] = wd1;
          end
          for (int k = 0; k < 2; k++) begin
            if (rf[k]) begin
              e_rv[d][k] = 1'b1;
              e_rd[d][k*32 +: 32] = (d == 1 && ra[k*5 +: 5] == 5'd0) ? 32'd0 : nm[ra[k*5 +: 5]];
            end else begin
              e_rv[d][k] = 1'b0;
              e_rd[d][k*32 +: 32] = 32'd0;
            end
          end
          for (int i = 0; i < DEPTH; i++) mm[d][i] = clr ? 32'd0 : nm[i];
        end
        if (clr) busy_left = DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy_z1",  64'(busy_z1), 64'(busy_left > 0));
      chk("busy_z0",  64'(busy_z0), 64'(busy_left > 0));
      chk("valid_z1", 64'(rv_z1), 64'(e_rv[1]));
      chk("valid_z0", 64'(rv_z0), 64'(e_rv[0]));
      chk("data_z1",  rd_z1, e_rd[1]);
      chk("data_z0",  rd_z0, e_rd[0]);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wf0 = 1'b0; wf1 = 1'b0; rf = 2'b00; clr = 1'b0;
  endtask

  // Called at the negedge where reset is released; counts that cycle too.
  task automatic count_busy(input string name);
    int cnt = 0;
    if (busy_z1) cnt++;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy_z1) cnt++;
      else break;
    end
    chk(name, 64'(cnt), 64'd32);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_z1 && n < 64) begin
      step();
      n++;
    end
    chk(name, 64'(busy_z1), 64'd0);
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle_in();
    step(); step(); step();
    count_busy("busy_len_reset");

    for (int i = 0; i < 16; i++) begin
      idle_in(); rf = 2'b11; ra = {5'(2*i+1), 5'(2*i)};
      step();
      chk("sweep_zero_z1", rd_z1, 64'd0);
      chk("sweep_zero_z0", rd_z0, 64'd0);
      chk("sweep_valid", 64'(rv_z1), 64'd3);
    end

    idle_in(); wf0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; step();
    idle_in(); rf = 2'b01; ra = {5'd0, 5'd5}; step();
    chk("rd_x5", 64'(port(rd_z1, 0)), 64'hDEADBEEF);
    chk("model_x5", 64'(port(e_rd[1], 0)), 64'hDEADBEEF);

    idle_in(); wf0 = 1'b1; wa0 = 5'd7; wd0 = 32'h12345678; rf = 2'b10; ra = {5'd7, 5'd0}; step();
    chk("bypass_x7", 64'(port(rd_z1, 1)), 64'h12345678);
    chk("bypass_x7_valid", 64'(rv_z1), 64'd2);

    idle_in(); wf0 = 1'b1; wf1 = 1'b1; wa0 = 5'd9; wa1 = 5'd9;
    wd0 = 32'h1111; wd1 = 32'h2222; rf = 2'b01; ra = {5'd0, 5'd9}; step();
    chk("collide_bypass", 64'(port(rd_z1, 0)), 64'h2222);
    chk("model_collide", 64'(port(e_rd[1], 0)), 64'h2222);
    idle_in(); step();
    idle_in(); rf = 2'b10; ra = {5'd9, 5'd0}; step();
    chk("collide_later", 64'(port(rd_z1, 1)), 64'h2222);

    idle_in(); wf0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; rf = 2'b01; ra = 10'd0; step();
    chk("x0_z1_data", 64'(port(rd_z1, 0)), 64'd0);
    chk("x0_z1_valid", 64'(rv_z1), 64'd1);
    chk("x0_z0_bypass", 64'(port(rd_z0, 0)), 64'hFFFFFFFF);
    idle_in(); rf = 2'b01; ra = 10'd0; step();
    chk("x0_z1_later", 64'(port(rd_z1, 0)), 64'd0);
    chk("x0_z0_later", 64'(port(rd_z0, 0)), 64'hFFFFFFFF);

    idle_in(); wf1 = 1'b1; wa1 = 5'd3; wd1 = 32'hA5A5A5A5; step();
    idle_in(); rf = 2'b00; ra = {5'd3, 5'd3}; step();
    chk("disabled_data", rd_z1, 64'd0);
    chk("disabled_valid", 64'(rv_z1), 64'd0);
    idle_in(); rf = 2'b10; ra = {5'd3, 5'd0}; step();
    chk("x3_loaded", 64'(port(rd_z1, 1)), 64'hA5A5A5A5);

    idle_in(); wf0 = 1'b1; wa0 = 5'd1; wd0 = 32'h11; wf1 = 1'b1; wa1 = 5'd2; wd1 = 32'h22; step();
    idle_in(); wf0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33; wf1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44; step();
    idle_in(); clr = 1'b1; wf0 = 1'b1; wa0 = 5'd1; wd0 = 32'h55; rf = 2'b01; ra = {5'd0, 5'd1}; step();
    chk("clear_req_read", 64'(port(rd_z1, 0)), 64'h11);
    chk("clear_busy", 64'(busy_z1), 64'd1);
    idle_in(); wf0 = 1'b1; wa0 = 5'd2; wd0 = 32'h77; rf = 2'b11; ra = {5'd2, 5'd2}; step();
    chk("busy_read_valid", 64'(rv_z1), 64'd0);
    idle_in();
    wait_idle("clear_done");
    for (int i = 1; i <= 4; i++) begin
      idle_in(); rf = 2'b11; ra = {5'(i), 5'(i)}; step();
      chk("after_clear", rd_z1, 64'd0);
      chk("after_clear_valid", 64'(rv_z1), 64'd3);
    end

    idle_in(); clr = 1'b1; step();
    idle_in();
    repeat (9) step();
    rst = 1'b0; step();
    count_busy("busy_len_midreset");

    for (int c = 0; c < 3000; c++) begin
      wf0 = 1'($urandom_range(0, 1));
      wf1 = 1'($urandom_range(0, 1));
      wa0 = raddr();
      wa1 = raddr();
      wd0 = $urandom();
      wd1 = $urandom();
      rf  = 2'($urandom_range(0, 3));
      ra  = {raddr(), raddr()};
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 599) != 0);
      step();
    end
    rst = 1'b1;
    idle_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
